// File: rtl/k16_uart_port.sv
// K16 I/O-bus UART responder (FFF8-FFFF): TX FIFO + serialiser, 1-cycle registered reads.
// Define K16_UART_RX_EN to build the receiver, RX FIFO, RX status bits and RX-driven irq.

module k16_uart_port #(
  parameter int unsigned DEFAULT_DIV = 217,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  addr,
  input  logic [15:0] din,
  input  logic        write_en,
  input  logic        read_en,
  output logic [15:0] dout,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_DIV    = 3'd2;

  typedef logic [FIFO_AW:0] ptr_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [15:0] div_reg;
  logic [15:0] div_eff;
  logic        data_wr;
  logic        div_wr;

  assign data_wr = write_en && (addr == A_DATA);
  assign div_wr  = write_en && (addr == A_DIV);
  assign div_eff = (div_reg < 16'd4) ? 16'd4 : div_reg;

  // ---------------- TX FIFO ----------------
  logic [7:0] tx_mem [DEPTH];
  ptr_t       tx_wr_ptr_reg;
  ptr_t       tx_rd_ptr_reg;
  logic       tx_fifo_empty;
  logic       tx_full;
  logic       tx_push;
  logic       tx_pop;

  assign tx_fifo_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
  assign tx_full = (tx_wr_ptr_reg[FIFO_AW] != tx_rd_ptr_reg[FIFO_AW]) &&
                   (tx_wr_ptr_reg[FIFO_AW-1:0] == tx_rd_ptr_reg[FIFO_AW-1:0]);
  assign tx_push = data_wr && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg[FIFO_AW-1:0]] <= din[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + ptr_t'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + ptr_t'(1);
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t   tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next;
  logic [15:0] tx_div_reg, tx_div_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic        tx_tick;
  logic        tx_busy;
  logic        tx_empty;

  assign tx_tick  = (tx_cnt_reg == tx_div_reg - 16'd1);
  assign tx_busy  = (tx_state_reg != TX_IDLE);
  assign tx_empty = tx_fifo_empty && !tx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_div_reg   <= 16'(DEFAULT_DIV);
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_div_reg   <= tx_div_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg + 16'd1;
    tx_div_next   = tx_div_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_cnt_next = '0;
        if (!tx_fifo_empty) begin
          tx_pop        = 1'b1;
          tx_shift_next = tx_mem[tx_rd_ptr_reg[FIFO_AW-1:0]];
          tx_div_next   = div_eff;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
          else                    tx_bit_next   = tx_bit_reg + 3'd1;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_cnt_next = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!tx_fifo_empty) begin
            tx_pop        = 1'b1;
            tx_shift_next = tx_mem[tx_rd_ptr_reg[FIFO_AW-1:0]];
            tx_div_next   = div_eff;
            tx_state_next = TX_START;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_reg)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift_reg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  // ---------------- Receiver ----------------
  logic        rx_avail;
  logic        rx_overrun_reg;
  logic        rx_frame_err_reg;
  logic [15:0] rx_data_word;
  logic        irq_src;

`ifdef K16_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        status_wr;
  logic        data_rd;
  logic [1:0]  rx_sync_reg;
  logic        rx_prev_reg;
  logic        rx_bit;
  logic        rx_fall;
  rx_state_t   rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next;
  logic [15:0] rx_div_reg, rx_div_next;
  logic [2:0]  rx_bitn_reg, rx_bitn_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic        rx_stop_ok;
  logic        rx_ferr_set;
  logic [7:0]  rx_mem [DEPTH];
  ptr_t        rx_wr_ptr_reg;
  ptr_t        rx_rd_ptr_reg;
  logic        rx_empty;
  logic        rx_full;
  logic        rx_push;
  logic        rx_pop;
  logic        rx_ovr_set;

  assign status_wr = write_en && (addr == A_STATUS);
  assign data_rd   = read_en && (addr == A_DATA);
  assign rx_bit    = rx_sync_reg[1];
  assign rx_fall   = rx_prev_reg && !rx_bit;

  assign rx_empty   = (rx_wr_ptr_reg == rx_rd_ptr_reg);
  assign rx_full    = (rx_wr_ptr_reg[FIFO_AW] != rx_rd_ptr_reg[FIFO_AW]) &&
                      (rx_wr_ptr_reg[FIFO_AW-1:0] == rx_rd_ptr_reg[FIFO_AW-1:0]);
  assign rx_push    = rx_stop_ok && !rx_full;
  assign rx_ovr_set = rx_stop_ok && rx_full;
  assign rx_pop     = data_rd && !rx_empty;
  assign rx_avail   = !rx_empty;
  assign rx_data_word = rx_empty ? 16'h0000 : {1'b1, 7'b0, rx_mem[rx_rd_ptr_reg[FIFO_AW-1:0]]};
  assign irq_src    = rx_avail;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg[FIFO_AW-1:0]] <= rx_shift_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_reg      <= 2'b11;
      rx_prev_reg      <= 1'b1;
      rx_wr_ptr_reg    <= '0;
      rx_rd_ptr_reg    <= '0;
      rx_overrun_reg   <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      rx_state_reg     <= RX_IDLE;
      rx_cnt_reg       <= '0;
      rx_div_reg       <= 16'(DEFAULT_DIV);
      rx_bitn_reg      <= '0;
      rx_shift_reg     <= '0;
    end else begin
      rx_sync_reg  <= {rx_sync_reg[0], uart_rx};
      rx_prev_reg  <= rx_bit;
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + ptr_t'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + ptr_t'(1);
      // A new error event wins over a same-cycle clear.
      if (rx_ovr_set)                  rx_overrun_reg <= 1'b1;
      else if (status_wr && din[3])    rx_overrun_reg <= 1'b0;
      if (rx_ferr_set)                 rx_frame_err_reg <= 1'b1;
      else if (status_wr && din[4])    rx_frame_err_reg <= 1'b0;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_div_reg   <= rx_div_next;
      rx_bitn_reg  <= rx_bitn_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg + 16'd1;
    rx_div_next   = rx_div_reg;
    rx_bitn_next  = rx_bitn_reg;
    rx_shift_next = rx_shift_reg;
    rx_stop_ok    = 1'b0;
    rx_ferr_set   = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (rx_fall) begin
          rx_div_next   = div_eff;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        // Half a bit in: confirms the start bit and aligns later samples to bit centres.
        if (rx_cnt_reg == (rx_div_reg >> 1) - 16'd1) begin
          rx_cnt_next   = '0;
          rx_bitn_next  = '0;
          rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == rx_div_reg - 16'd1) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_bit, rx_shift_reg[7:1]};
          if (rx_bitn_reg == 3'd7) rx_state_next = RX_STOP;
          else                     rx_bitn_next  = rx_bitn_reg + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == rx_div_reg - 16'd1) begin
          rx_cnt_next   = '0;
          rx_stop_ok    = rx_bit;
          rx_ferr_set   = !rx_bit;
          rx_state_next = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end
`else
  logic unused_rx;
  assign unused_rx        = uart_rx;
  assign rx_avail         = 1'b0;
  assign rx_overrun_reg   = 1'b0;
  assign rx_frame_err_reg = 1'b0;
  assign rx_data_word     = 16'h0000;
  assign irq_src          = tx_empty;
`endif

  // ---------------- Register file / read port ----------------
  logic [15:0] status_word;
  logic [15:0] rd_data;
  logic [15:0] dout_reg;
  logic        irq_reg;

  assign status_word = {10'b0, tx_busy, rx_frame_err_reg, rx_overrun_reg, rx_avail, tx_empty, tx_full};

  always_comb begin
    rd_data = 16'h0000;
    case (addr)
      A_DATA:   rd_data = rx_data_word;
      A_STATUS: rd_data = status_word;
      A_DIV:    rd_data = div_reg;
      default:  rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg  <= 16'(DEFAULT_DIV);
      dout_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      if (div_wr)  div_reg  <= din;
      if (read_en) dout_reg <= rd_data;
      irq_reg <= irq_src;
    end
  end

  assign dout = dout_reg;
  assign irq  = irq_reg;

endmodule
